// File: rtl/axis_fifo_transmitter_pkg.sv
// Shared types and constants for the AXI-Stream FIFO transmitter.
// Holds the output-stage state encoding and the beat-counter width.
package axis_fifo_transmitter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_e;

  localparam int unsigned BEAT_CNT_W = 16;

  // Level counters carry one extra bit so a full buffer is distinguishable from empty.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_transmitter_if.sv
// AXI-Stream beat bundle driven by the transmitter output stage.
interface axis_fifo_transmitter_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_fifo_transmitter_sync_fifo.sv
// Single-clock buffer: storage array, wrapping pointers and occupancy level.
// Head entry is readable combinationally so the output stage can load it on the next edge.
module axis_sync_fifo
  import axis_fifo_transmitter_pkg::*;
#(
  parameter int WIDTH = 257,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);

endmodule

// File: rtl/axis_fifo_transmitter.sv
// Buffered AXI-Stream transmitter: upstream valid/ready into a FIFO, then a
// one-beat output register with optional fixed-length tlast generation.
module axis_fifo_transmitter
  import axis_fifo_transmitter_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_DATA_KEEP  = AXIS_DATA_WIDTH / 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int PKT_LEN         = 400,
  parameter int LAST_MODE       = 0,
  localparam int LVL_W          = level_width(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       transmit_vld,
  input  logic [AXIS_DATA_WIDTH-1:0] transmit_data,
  input  logic                       transmit_last,
  output logic                       transmit_rdy,
  axis_fifo_transmitter_if.master    AXIS_data_transmitter_AXIS,
  output logic [LVL_W-1:0]           fifo_level,
  output logic                       pkt_done
);

  localparam int FW = AXIS_DATA_WIDTH + 1;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(PKT_LEN - 1);

  logic                       fifo_wr_en;
  logic                       fifo_rd_en;
  logic [FW-1:0]              fifo_rd_data;
  logic                       fifo_full;
  logic                       fifo_empty;

  out_state_e                 state_reg;
  out_state_e                 state_next;
  logic [AXIS_DATA_WIDTH-1:0] tdata_reg;
  logic                       tlast_reg;
  logic                       tlast_next;
  logic [BEAT_CNT_W-1:0]      cnt_reg;
  logic [BEAT_CNT_W-1:0]      cnt_next;
  logic                       pkt_done_reg;
  logic                       handshake;

  assign transmit_rdy = !fifo_full;
  assign fifo_wr_en   = transmit_vld && transmit_rdy;

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr_en),
    .wr_data ({transmit_last, transmit_data}),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign handshake = (state_reg == HOLD) && AXIS_data_transmitter_AXIS.tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // A held beat is only released by tready; en merely gates loading the next one.
  always_comb begin
    state_next = state_reg;
    fifo_rd_en = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (en && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (AXIS_data_transmitter_AXIS.tready) begin
          if (en && !fifo_empty) fifo_rd_en = 1'b1;
          else                   state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Counter value seen by the beat being loaded now, after any same-cycle handshake.
  always_comb begin
    cnt_next   = cnt_reg;
    tlast_next = fifo_rd_data[FW-1];
    if (LAST_MODE != 0) begin
      if (handshake) cnt_next = tlast_reg ? '0 : cnt_reg + 1'b1;
      tlast_next = (cnt_next == LAST_BEAT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_reg    <= '0;
      tlast_reg    <= 1'b0;
      cnt_reg      <= '0;
      pkt_done_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      pkt_done_reg <= handshake && tlast_reg;
      if (fifo_rd_en) begin
        tdata_reg <= fifo_rd_data[AXIS_DATA_WIDTH-1:0];
        tlast_reg <= tlast_next;
      end
    end
  end

  assign AXIS_data_transmitter_AXIS.tvalid = (state_reg == HOLD);
  assign AXIS_data_transmitter_AXIS.tdata  = tdata_reg;
  assign AXIS_data_transmitter_AXIS.tlast  = tlast_reg;
  assign AXIS_data_transmitter_AXIS.tkeep  = '1;
  assign pkt_done = pkt_done_reg;

endmodule

// File: tb/tb_axis_fifo_transmitter.sv
// Drives a pass-through instance (LAST_MODE=0) and a counted-packet instance
// (LAST_MODE=1, PKT_LEN=4) with identical stimulus, checked against a queue model.
module tb_axis_fifo_transmitter;

  localparam int DW    = 256;
  localparam int KW    = 32;
  localparam int DEPTH = 16;
  localparam int PLEN  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          vld = 1'b0;
  logic          last = 1'b0;
  logic [DW-1:0] data = '0;
  logic          tready = 1'b0;
  logic          rdy0, rdy1, done0, done1;
  logic [4:0]    lvl0, lvl1;

  always #5 clk = ~clk;

  axis_fifo_transmitter_if #(.DATA_WIDTH(DW)) ax0 ();
  axis_fifo_transmitter_if #(.DATA_WIDTH(DW)) ax1 ();
  assign ax0.tready = tready;
  assign ax1.tready = tready;

  axis_fifo_transmitter #(.AXIS_DATA_WIDTH(DW), .AXIS_DATA_KEEP(KW), .FIFO_DEPTH(DEPTH),
                          .PKT_LEN(400), .LAST_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .transmit_vld(vld), .transmit_data(data),
    .transmit_last(last), .transmit_rdy(rdy0), .AXIS_data_transmitter_AXIS(ax0),
    .fifo_level(lvl0), .pkt_done(done0));

  axis_fifo_transmitter #(.AXIS_DATA_WIDTH(DW), .AXIS_DATA_KEEP(KW), .FIFO_DEPTH(DEPTH),
                          .PKT_LEN(PLEN), .LAST_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .transmit_vld(vld), .transmit_data(data),
    .transmit_last(last), .transmit_rdy(rdy1), .AXIS_data_transmitter_AXIS(ax1),
    .fifo_level(lvl1), .pkt_done(done1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: every accepted input beat in order, one read index per instance.
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  int            rd_idx[2];
  int            out_cnt[2];
  int            hs_cnt[2];
  int            done_cnt[2];
  logic          exp_done[2];
  logic          stall[2];
  logic [DW-1:0] held_data[2];
  logic          held_last[2];

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    exp_data.delete();
    exp_last.delete();
    for (int k = 0; k < 2; k++) begin
      rd_idx[k] = 0; out_cnt[k] = 0; exp_done[k] = 1'b0; stall[k] = 1'b0;
    end
  endtask

  task automatic rand_beat();
    for (int w = 0; w < DW / 32; w++) data[w*32 +: 32] = $urandom();
  endtask

  // Evaluates the coming edge against the model, then advances to the next falling edge.
  task automatic tick();
    logic [DW-1:0] s_data[2];
    logic          s_last[2], s_valid[2], s_done[2];
    logic          want_last;
    s_data[0] = ax0.tdata;  s_last[0] = ax0.tlast;  s_valid[0] = ax0.tvalid;  s_done[0] = done0;
    s_data[1] = ax1.tdata;  s_last[1] = ax1.tlast;  s_valid[1] = ax1.tvalid;  s_done[1] = done1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pkt_done%0d", k), s_done[k], exp_done[k]);
      if (s_done[k]) done_cnt[k]++;
      exp_done[k] = 1'b0;
      if (stall[k]) begin
        check($sformatf("hold_data%0d", k), s_data[k], held_data[k]);
        check($sformatf("hold_last%0d", k), s_last[k], held_last[k]);
      end
      if (s_valid[k] && tready) begin
        if (rd_idx[k] >= exp_data.size()) begin
          check($sformatf("unexpected_beat%0d", k), 1'b1, 1'b0);
        end else begin
          want_last = (k == 0) ? exp_last[rd_idx[k]] : ((out_cnt[k] % PLEN) == PLEN - 1);
          check($sformatf("out_data%0d", k), s_data[k], exp_data[rd_idx[k]]);
          check($sformatf("out_last%0d", k), s_last[k], want_last);
          exp_done[k] = want_last;
          rd_idx[k]++;
        end
        out_cnt[k]++;
        hs_cnt[k]++;
      end
      stall[k]     = s_valid[k] && !tready;
      held_data[k] = s_data[k];
      held_last[k] = s_last[k];
    end
    if (rdy0 !== rdy1) check("rdy_match", rdy1, rdy0);
    if (vld && rdy0) begin
      exp_data.push_back(data);
      exp_last.push_back(last);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    vld = 1'b0; en = 1'b1; tready = 1'b1;
    while (n < budget && (rd_idx[0] < exp_data.size() || rd_idx[1] < exp_data.size()
                          || ax0.tvalid || ax1.tvalid)) begin
      tick();
      n++;
    end
    check("drain_left0", 32'(exp_data.size() - rd_idx[0]), 0);
    check("drain_left1", 32'(exp_data.size() - rd_idx[1]), 0);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous effect before any clock edge.
  task automatic reset_now();
    #2 rst_n = 1'b0;
    vld = 1'b0;
    #1;
    check("rst_tvalid0", ax0.tvalid, 1'b0);
    check("rst_tvalid1", ax1.tvalid, 1'b0);
    check("rst_level0", lvl0, 5'd0);
    check("rst_rdy0", rdy0, 1'b1);
    check("rst_done0", done0, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int h0, d1, writes, guard;
    for (int k = 0; k < 2; k++) begin hs_cnt[k] = 0; done_cnt[k] = 0; end
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("init_tvalid", ax0.tvalid, 1'b0);
    check("init_tdata", ax0.tdata, '0);
    check("init_tlast", ax0.tlast, 1'b0);
    check("init_level", lvl0, 5'd0);
    check("init_rdy", rdy0, 1'b1);
    check("init_done", done0, 1'b0);
    check("tkeep", ax0.tkeep, {KW{1'b1}});
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat latency and pkt_done timing
    en = 1'b1; tready = 1'b1; vld = 1'b1; data = 256'hA5; last = 1'b1;
    tick();
    vld = 1'b0; last = 1'b0;
    check("lat_tvalid_e0", ax0.tvalid, 1'b0);
    check("lat_level_e0", lvl0, 5'd1);
    tick();
    check("lat_tvalid_e1", ax0.tvalid, 1'b1);
    check("lat_tdata_e1", ax0.tdata, 256'hA5);
    check("lat_tlast_e1", ax0.tlast, 1'b1);
    check("lat_tlast1_e1", ax1.tlast, 1'b0);
    tick();
    check("lat_done_e2", done0, 1'b1);
    tick();
    $display("phase latency: %0d compared", n_cmp);

    // Fill: one held, sixteen buffered, then back-to-back drain
    reset_now();
    tready = 1'b0; en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      vld = 1'b1; rand_beat(); last = 1'($urandom_range(0, 1));
      tick();
    end
    vld = 1'b0;
    check("full_level", lvl0, 5'd16);
    check("full_rdy", rdy0, 1'b0);
    check("full_tvalid", ax0.tvalid, 1'b1);
    tready = 1'b1;
    h0 = hs_cnt[0];
    repeat (DEPTH + 1) tick();
    check("full_beats_out", 32'(hs_cnt[0] - h0), 17);
    check("full_empty_after", ax0.tvalid, 1'b0);
    $display("phase fill: %0d compared", n_cmp);

    // Generated tlast every fourth beat
    reset_now();
    tready = 1'b1; en = 1'b1;
    d1 = done_cnt[1];
    for (int i = 0; i < 12; i++) begin
      vld = 1'b1; rand_beat(); last = 1'b0;
      tick();
    end
    vld = 1'b0;
    repeat (5) tick();
    check("pkt_done_pulses", 32'(done_cnt[1] - d1), 3);
    check("pkt_beats", 32'(rd_idx[1]), 12);
    $display("phase last_mode: %0d compared", n_cmp);

    // en=0 pauses loading
    reset_now();
    en = 1'b0; tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; rand_beat(); last = 1'($urandom_range(0, 1));
      tick();
    end
    vld = 1'b0;
    repeat (5) tick();
    check("pause_tvalid", ax0.tvalid, 1'b0);
    check("pause_level", lvl0, 5'd3);
    en = 1'b1;
    h0 = hs_cnt[0];
    repeat (6) tick();
    check("pause_beats_out", 32'(hs_cnt[0] - h0), 3);
    $display("phase pause: %0d compared", n_cmp);

    // Random backpressure, gating and gaps over 1000 beats
    writes = 0; guard = 0;
    while (writes < 1000 && guard < 20000) begin
      vld    = ($urandom_range(0, 9) < 7);
      tready = 1'($urandom_range(0, 1));
      en     = ($urandom_range(0, 9) < 8);
      rand_beat(); last = ($urandom_range(0, 4) == 0);
      if (vld && rdy0) writes++;
      tick();
      guard++;
    end
    check("random_writes", 32'(writes), 1000);
    drain(200);
    $display("phase random: %0d compared", n_cmp);

    // Reset with beats buffered and one held
    reset_now();
    tready = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vld = 1'b1; rand_beat(); last = 1'b0;
      tick();
    end
    vld = 1'b0;
    check("pre_rst_level", lvl0, 5'd5);
    check("pre_rst_tvalid", ax0.tvalid, 1'b1);
    reset_now();
    tready = 1'b1; en = 1'b1;
    repeat (5) tick();
    check("post_rst_tvalid", ax0.tvalid, 1'b0);
    vld = 1'b1; rand_beat(); last = 1'b1;
    tick();
    drain(20);
    $display("phase reset: %0d compared", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
